// File: rtl/pocket_scan_ctrl_if.sv
// pocket_scan_ctrl_if: ball-unit and hole-lookup signals of the pocket scanner
//   req/ballX/ballY      ball units -> scanner (level request, packed coordinates)
//   targetX/targetY      hole lookup -> scanner (registered, 1 clk after hole)
//   hole                 scanner -> hole lookup (0..5)
//   grant/busy/done/pocketed/pocketHole  scanner -> ball units (scan owner and result)
//   master: the ball units and lookup side; slave: the scanner
interface pocket_scan_ctrl_if #(
   parameter int NUM_BALLS = 4,
   parameter int COORD_W   = 11
);
   logic [NUM_BALLS-1:0]         req, grant;
   logic [NUM_BALLS*COORD_W-1:0] ballX, ballY;
   logic [COORD_W-1:0]           targetX, targetY;
   logic [2:0]                   hole, pocketHole;
   logic                         busy, done, pocketed;
   modport master (output req, ballX, ballY, targetX, targetY,
                   input  hole, grant, busy, done, pocketed, pocketHole);
   modport slave  (input  req, ballX, ballY, targetX, targetY,
                   output hole, grant, busy, done, pocketed, pocketHole);
endinterface

// File: rtl/pocket_scan_ctrl.sv
// pocket_scan_ctrl: round-robin time-share of the hole lookup, scans holes 0..5 for pocketing
//   clk    system clock
//   reset  asynchronous active-high reset
//   bus    pocket_scan_ctrl_if.slave: req/ballX/ballY/targetX/targetY in,
//          hole/grant/busy/done/pocketed/pocketHole out
module pocket_scan_ctrl #(
   parameter int NUM_BALLS = 4,
   parameter int COORD_W   = 11,
   parameter int POCKET_R2 = 256
) (
   input logic               clk,
   input logic               reset,
   pocket_scan_ctrl_if.slave bus
);
   localparam int IW = $clog2(NUM_BALLS);
   localparam int SW = 2 * COORD_W;
   typedef enum logic [2:0] {IDLE, SETH, WAIT, CMP, DONE} state_t;
   state_t state, state_nx;
   logic [IW-1:0] ptr, sel, idx;
   logic found, hit, pocketed;
   logic [NUM_BALLS-1:0] grant;
   logic [2:0] hole, pocket_hole;
   logic [COORD_W-1:0] bx, by, dx, dy;
   logic [SW-1:0] dx2, dy2;
   logic [SW:0] sum;
   // first requester at or after the round-robin pointer, wrapping
   always_comb begin
      sel = '0;
      idx = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_BALLS; i++) begin
         idx = IW'((int'(ptr) + i) % NUM_BALLS);
         if (!found && bus.req[idx]) begin
            found = 1'b1;
            sel = idx;
         end
      end
   end
   // magnitude by compare-then-subtract so a ball left/above the hole never wraps
   assign dx  = (bx >= bus.targetX) ? bx - bus.targetX : bus.targetX - bx;
   assign dy  = (by >= bus.targetY) ? by - bus.targetY : bus.targetY - by;
   assign sum = (SW+1)'(dx2) + (SW+1)'(dy2);
   assign hit = sum <= (SW+1)'(POCKET_R2);
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else       state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = found ? SETH : IDLE;
         SETH:    state_nx = WAIT;
         WAIT:    state_nx = CMP;
         CMP:     state_nx = (hit || hole == 3'd5) ? DONE : SETH;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         ptr         <= '0;
         grant       <= '0;
         hole        <= '0;
         bx          <= '0;
         by          <= '0;
         dx2         <= '0;
         dy2         <= '0;
         pocketed    <= 1'b0;
         pocket_hole <= '0;
      end else begin
         case (state)
            IDLE: if (found) begin
               grant <= NUM_BALLS'(1) << sel;
               bx    <= bus.ballX[int'(sel)*COORD_W +: COORD_W];
               by    <= bus.ballY[int'(sel)*COORD_W +: COORD_W];
               hole  <= '0;
               ptr   <= (sel == IW'(NUM_BALLS-1)) ? '0 : sel + 1'b1;
            end
            WAIT: begin
               dx2 <= SW'(dx) * SW'(dx);
               dy2 <= SW'(dy) * SW'(dy);
            end
            CMP: begin
               if (hit || hole == 3'd5) begin
                  pocketed    <= hit;
                  pocket_hole <= hit ? hole : 3'd0;
               end else
                  hole <= hole + 3'd1;
            end
            DONE: begin
               grant <= '0;
               hole  <= '0;
            end
            default: ;
         endcase
      end
   assign bus.grant      = grant;
   assign bus.hole       = hole;
   assign bus.busy       = state != IDLE;
   assign bus.done       = state == DONE;
   assign bus.pocketed   = pocketed;
   assign bus.pocketHole = pocket_hole;
endmodule
